// File: rtl/mips32_selftest_seq_if.sv
// mips32_selftest_seq_if: bundles every non-clock/reset signal of the self-test sequencer.
//   cfg_we/cfg_sel/cfg_idx/cfg_data  host config writes (program, expected values, check regs,
//                                    lengths)
//   start                            host start pulse
//   imem_we/imem_addr/imem_wdata     core instruction-memory write port
//   cpu_rst/cpu_halted               core reset control and halt status
//   rf_raddr/rf_rdata                core register-file debug read port (1-cycle read latency)
//   busy/done/pass/timeout/fail_idx/fail_data/run_cycles  status back to the host
//   err_count                        mismatch count, present only with SELFTEST_ALLCHK_EN
// Modports: master = sequencer side, slave = host + core side.
// Optional feature macro: SELFTEST_ALLCHK_EN.
interface mips32_selftest_seq_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PROG_DEPTH = 16,
  parameter int unsigned NUM_CHECK  = 8,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned CNT_W      = 16
);
  localparam int unsigned PIW = $clog2(PROG_DEPTH);
  localparam int unsigned CIW = $clog2(NUM_CHECK);

  logic              cfg_we;
  logic [1:0]        cfg_sel;
  logic [PIW-1:0]    cfg_idx;
  logic [DATA_W-1:0] cfg_data;
  logic              start;

  logic              imem_we;
  logic [PIW-1:0]    imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_rst;
  logic              cpu_halted;
  logic [REG_AW-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;

  logic              busy;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [CIW-1:0]    fail_idx;
  logic [DATA_W-1:0] fail_data;
  logic [CNT_W-1:0]  run_cycles;
`ifdef SELFTEST_ALLCHK_EN
  logic [$clog2(NUM_CHECK+1)-1:0] err_count;

  modport master (
    input  cfg_we, cfg_sel, cfg_idx, cfg_data, start, cpu_halted, rf_rdata,
    output imem_we, imem_addr, imem_wdata, cpu_rst, rf_raddr,
    output busy, done, pass, timeout, fail_idx, fail_data, run_cycles, err_count
  );
  modport slave (
    output cfg_we, cfg_sel, cfg_idx, cfg_data, start, cpu_halted, rf_rdata,
    input  imem_we, imem_addr, imem_wdata, cpu_rst, rf_raddr,
    input  busy, done, pass, timeout, fail_idx, fail_data, run_cycles, err_count
  );
`else
  modport master (
    input  cfg_we, cfg_sel, cfg_idx, cfg_data, start, cpu_halted, rf_rdata,
    output imem_we, imem_addr, imem_wdata, cpu_rst, rf_raddr,
    output busy, done, pass, timeout, fail_idx, fail_data, run_cycles
  );
  modport slave (
    output cfg_we, cfg_sel, cfg_idx, cfg_data, start, cpu_halted, rf_rdata,
    input  imem_we, imem_addr, imem_wdata, cpu_rst, rf_raddr,
    input  busy, done, pass, timeout, fail_idx, fail_data, run_cycles
  );
`endif
endinterface

// File: rtl/mips32_selftest_seq.sv
// mips32_selftest_seq: self-test sequencer for the mips32 core family.
// Loads a program into core imem with the core held in reset, releases the core, waits for
// halt (or TIMEOUT run cycles), then reads back a list of registers and compares them against
// expected values, reporting pass/fail.
// Ports:
//   clk  system clock, all state on the rising edge
//   rst  asynchronous active-high reset
//   bus  mips32_selftest_seq_if.master (config/host port, imem write port, core reset/halt,
//        register-file debug read port, status outputs)
// Config (cfg_sel): 0 program word, 1 expected value, 2 check-register index,
//   3 lengths with prog_len in the upper half of cfg_data and chk_len in the lower half.
// Optional feature macro: SELFTEST_ALLCHK_EN -- compare every checked register instead of
//   stopping at the first mismatch and count mismatches in err_count.
module mips32_selftest_seq #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PROG_DEPTH = 16,
  parameter int unsigned NUM_CHECK  = 8,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned TIMEOUT    = 256,
  parameter int unsigned CNT_W      = 16
) (
  input logic                   clk,
  input logic                   rst,
  mips32_selftest_seq_if.master bus
);
  localparam int unsigned PIW = $clog2(PROG_DEPTH);
  localparam int unsigned CIW = $clog2(NUM_CHECK);
  localparam int unsigned PLW = $clog2(PROG_DEPTH + 1);
  localparam int unsigned CLW = $clog2(NUM_CHECK + 1);
  localparam int unsigned HW  = DATA_W / 2;

  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StRead, StCmp, StDone} state_e;

  state_e state_q, state_d;

  // Config tables and lengths are deliberately not reset so they survive a mid-run abort.
  logic [DATA_W-1:0] prog_mem [PROG_DEPTH];
  logic [DATA_W-1:0] exp_mem  [NUM_CHECK];
  logic [REG_AW-1:0] chk_mem  [NUM_CHECK];
  logic [PLW-1:0]    prog_len_q;
  logic [CLW-1:0]    chk_len_q;

  logic [PIW-1:0]    ptr_q, ptr_d;
  logic [CIW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]  run_q, run_d;
  logic              pass_q, pass_d;
  logic              to_q, to_d;
  logic [CIW-1:0]    fidx_q, fidx_d;
  logic [DATA_W-1:0] fdata_q, fdata_d;
`ifdef SELFTEST_ALLCHK_EN
  logic [CLW-1:0]    err_q, err_d;
`endif

  // ---------------------------------------------------------------- config port
  logic           cfg_ok;
  logic           cfg_in_chk;
  logic [HW-1:0]  plen_f, clen_f;
  logic [PLW-1:0] plen_c;
  logic [CLW-1:0] clen_c;

  assign cfg_ok     = bus.cfg_we && (state_q == StIdle || state_q == StDone);
  assign cfg_in_chk = 32'(bus.cfg_idx) < NUM_CHECK;
  assign plen_f     = bus.cfg_data[DATA_W-1:HW];
  assign clen_f     = bus.cfg_data[HW-1:0];
  assign plen_c     = (plen_f > HW'(PROG_DEPTH)) ? PLW'(PROG_DEPTH) : PLW'(plen_f);
  assign clen_c     = (clen_f > HW'(NUM_CHECK))  ? CLW'(NUM_CHECK)  : CLW'(clen_f);

  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      unique case (bus.cfg_sel)
        2'd0: prog_mem[bus.cfg_idx] <= bus.cfg_data;
        2'd1: if (cfg_in_chk) exp_mem[bus.cfg_idx[CIW-1:0]] <= bus.cfg_data;
        2'd2: if (cfg_in_chk) chk_mem[bus.cfg_idx[CIW-1:0]] <= bus.cfg_data[REG_AW-1:0];
        2'd3: begin
          prog_len_q <= plen_c;
          chk_len_q  <= clen_c;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- sequencer FSM
  logic load_last;
  logic chk_last;
  logic mismatch;

  assign load_last = (PLW'(ptr_q) + PLW'(1)) >= prog_len_q;
  assign chk_last  = (CLW'(idx_q) + CLW'(1)) == chk_len_q;
  assign mismatch  = bus.rf_rdata != exp_mem[idx_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    run_d   = run_q;
    pass_d  = pass_q;
    to_d    = to_q;
    fidx_d  = fidx_q;
    fdata_d = fdata_q;
`ifdef SELFTEST_ALLCHK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StLoad;
          ptr_d   = '0;
          idx_d   = '0;
          run_d   = '0;
          pass_d  = 1'b0;
          to_d    = 1'b0;
          fidx_d  = '0;
          fdata_d = '0;
`ifdef SELFTEST_ALLCHK_EN
          err_d   = '0;
`endif
        end
      end
      StLoad: begin
        // prog_len = 0 falls straight through to RUN after one idle cycle with no write.
        if (load_last) state_d = StRun;
        else           ptr_d   = ptr_q + PIW'(1);
      end
      StRun: begin
        if (run_q != CNT_MAX) run_d = run_q + CNT_W'(1);
        // Halt has priority over a timeout landing on the same cycle.
        if (bus.cpu_halted) begin
          if (chk_len_q == '0) begin
            pass_d  = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StRead;
          end
        end else if (run_d >= TO_CNT) begin
          to_d    = 1'b1;
          pass_d  = 1'b0;
          state_d = StDone;
        end
      end
      StRead: state_d = StCmp;
      StCmp: begin
`ifdef SELFTEST_ALLCHK_EN
        if (mismatch) begin
          if (err_q == '0) begin
            fidx_d  = idx_q;
            fdata_d = bus.rf_rdata;
          end
          err_d = err_q + CLW'(1);
        end
        if (chk_last) begin
          pass_d  = (err_d == '0);
          state_d = StDone;
        end else begin
          idx_d   = idx_q + CIW'(1);
          state_d = StRead;
        end
`else
        if (mismatch) begin
          fidx_d  = idx_q;
          fdata_d = bus.rf_rdata;
          pass_d  = 1'b0;
          state_d = StDone;
        end else if (chk_last) begin
          pass_d  = 1'b1;
          state_d = StDone;
        end else begin
          idx_d   = idx_q + CIW'(1);
          state_d = StRead;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      run_q   <= '0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
      fidx_q  <= '0;
      fdata_q <= '0;
`ifdef SELFTEST_ALLCHK_EN
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      pass_q  <= pass_d;
      to_q    <= to_d;
      fidx_q  <= fidx_d;
      fdata_q <= fdata_d;
`ifdef SELFTEST_ALLCHK_EN
      err_q   <= err_d;
`endif
    end
  end

  // ---------------------------------------------------------------- outputs
  logic load_we;
  assign load_we = (state_q == StLoad) && (PLW'(ptr_q) < prog_len_q);

  assign bus.imem_we    = load_we;
  assign bus.imem_addr  = load_we ? ptr_q : '0;
  assign bus.imem_wdata = load_we ? prog_mem[ptr_q] : '0;
  // Core stays out of reset through readback so its register file is observable.
  assign bus.cpu_rst    = !(state_q == StRun || state_q == StRead || state_q == StCmp);
  assign bus.rf_raddr   = (state_q == StRead) ? chk_mem[idx_q] : '0;
  assign bus.busy       = (state_q == StLoad) || (state_q == StRun) ||
                          (state_q == StRead) || (state_q == StCmp);
  assign bus.done       = (state_q == StDone);
  assign bus.pass       = pass_q;
  assign bus.timeout    = to_q;
  assign bus.fail_idx   = fidx_q;
  assign bus.fail_data  = fdata_q;
  assign bus.run_cycles = run_q;
`ifdef SELFTEST_ALLCHK_EN
  assign bus.err_count  = err_q;
`endif

endmodule
